rx_frame_ctrl: RTL and testbench

Frame controller behind the UART byte receiver. Consumes the receiver's one-cycle `update`/`data` byte strobes, assembles them into command frames (sync, opcode, length, payload, checksum), and validates length and checksum. Enforces an inter-byte timeout and presents each good frame to the game logic over a valid/ready handshake. Malformed or dropped input is reported as an error pulse with a code.

---
 rtl/rx_frame_pkg.sv | 25 ++
 rtl/rx_frame_if.sv | 35 +++
 rtl/rx_frame_ctrl_idle_timer.sv | 30 +++
 rtl/rx_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_frame_pkg.sv
// Shared constants and types for the UART command-frame controller.
package rx_frame_pkg;

   // First byte of every command frame; it is not part of the checksum.
   localparam logic [7:0] SYNC_BYTE = 8'h55;

   // Frame assembly states, in byte order; IDLE encodes as zero.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_OP      = 3'd1,
      ST_LEN     = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_CHK     = 3'd4,
      ST_HOLD    = 3'd5
   } state_t;

   // Error code presented with each error pulse and held until the next one.
   typedef enum logic [1:0] {
      ERR_OVERRUN = 2'd0,
      ERR_BAD_LEN = 2'd1,
      ERR_BAD_CHK = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

endpackage

// File: rtl/rx_frame_if.sv
// Byte-strobe input, command handshake and error report of the frame controller.
//
// Handshake: rx_update is a one-cycle strobe with no back-pressure; rx_data is
// meaningful only while it is high. cmd_valid/cmd_ready is a strict valid/ready
// pair: once cmd_valid rises, cmd_op, cmd_len and cmd_payload stay stable and
// cmd_valid stays high until the cycle in which cmd_ready is also high; that
// cycle is the transfer.
interface rx_frame_if #(
   parameter int MAX_LEN = 8
);
   import rx_frame_pkg::*;

   logic                   rx_update;
   logic [7:0]             rx_data;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [7:0]             cmd_op;
   logic [3:0]             cmd_len;
   logic [8*MAX_LEN-1:0]   cmd_payload;
   logic                   err_pulse;
   err_code_t              err_code;

   // Controller side.
   modport master (
      input  rx_update, rx_data, cmd_ready,
      output cmd_valid, cmd_op, cmd_len, cmd_payload, err_pulse, err_code
   );

   // Receiver / game-logic side.
   modport slave (
      output rx_update, rx_data, cmd_ready,
      input  cmd_valid, cmd_op, cmd_len, cmd_payload, err_pulse, err_code
   );

endinterface

// File: rtl/rx_frame_ctrl_idle_timer.sv
// Inter-byte idle counter: counts while run is high, expires at TIMEOUT-1.
module idle_timer #(
   parameter int TIMEOUT = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int             CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q;

   // Count idle cycles; any byte or state change restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (run) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign expire = run && (count_q == LAST);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Assembles UART bytes into SYNC/OP/LEN/PAYLOAD/CHK frames, validates them and
// hands good frames to the consumer over valid/ready.
module rx_frame_ctrl
   import rx_frame_pkg::*;
#(
   parameter int TIMEOUT = 1_000_000,
   parameter int MAX_LEN = 8
) (
   input  logic           clk,
   input  logic           reset,
   rx_frame_if.master     bus,
   output state_t         dbg_state
);

   localparam int PW = 8 * MAX_LEN;

   // Every register of the block; outputs are driven straight from here.
   typedef struct packed {
      state_t     st;
      logic [7:0] sum;
      logic [3:0] idx;
      logic [7:0] op;
      logic [3:0] len;
      logic [PW-1:0] payload;
      logic       valid;
      logic       err_pulse;
      err_code_t  err_code;
   } regs_t;

   regs_t r_q;
   regs_t r_d;

   logic tmr_clear;
   logic tmr_run;
   logic tmr_expire;

   // Next-state and register update for the frame parser.
   always_comb begin
      r_d           = r_q;
      r_d.err_pulse = 1'b0;

      unique case (r_q.st)
         ST_IDLE: begin
            if (bus.rx_update && (bus.rx_data == SYNC_BYTE)) begin
               r_d.st      = ST_OP;
               r_d.payload = '0;
               r_d.sum     = '0;
               r_d.idx     = '0;
            end
         end

         ST_OP: begin
            if (bus.rx_update) begin
               r_d.op  = bus.rx_data;
               r_d.sum = bus.rx_data;
               r_d.st  = ST_LEN;
            end
         end

         ST_LEN: begin
            if (bus.rx_update) begin
               r_d.len = bus.rx_data[3:0];
               r_d.sum = r_q.sum + bus.rx_data;
               if (bus.rx_data > 8'(MAX_LEN)) begin
                  r_d.st        = ST_IDLE;
                  r_d.err_pulse = 1'b1;
                  r_d.err_code  = ERR_BAD_LEN;
               end else if (bus.rx_data == 8'd0) begin
                  r_d.st = ST_CHK;
               end else begin
                  r_d.st = ST_PAYLOAD;
               end
            end
         end

         ST_PAYLOAD: begin
            if (bus.rx_update) begin
               for (int i = 0; i < MAX_LEN; i++) begin
                  if (r_q.idx == 4'(i)) begin
                     r_d.payload[8*i +: 8] = bus.rx_data;
                  end
               end
               r_d.sum = r_q.sum + bus.rx_data;
               r_d.idx = r_q.idx + 4'd1;
               if ((r_q.idx + 4'd1) == r_q.len) begin
                  r_d.st = ST_CHK;
               end
            end
         end

         ST_CHK: begin
            if (bus.rx_update) begin
               if (bus.rx_data == r_q.sum) begin
                  r_d.st    = ST_HOLD;
                  r_d.valid = 1'b1;
               end else begin
                  r_d.st        = ST_IDLE;
                  r_d.err_pulse = 1'b1;
                  r_d.err_code  = ERR_BAD_CHK;
               end
            end
         end

         ST_HOLD: begin
            // A byte while holding is dropped; the held frame is untouched.
            if (bus.rx_update) begin
               r_d.err_pulse = 1'b1;
               r_d.err_code  = ERR_OVERRUN;
            end
            if (r_q.valid && bus.cmd_ready) begin
               r_d.st    = ST_IDLE;
               r_d.valid = 1'b0;
            end
         end

         default: begin
            r_d.st = ST_IDLE;
         end
      endcase

      // Timer only runs mid-frame; a byte in the expiry cycle takes priority.
      if (tmr_expire && !bus.rx_update) begin
         r_d.st        = ST_IDLE;
         r_d.err_pulse = 1'b1;
         r_d.err_code  = ERR_TIMEOUT;
      end
   end

   // Register bank; reset drops any partial or held frame without an error.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else begin
         r_q <= r_d;
      end
   end

   // Timer runs in the mid-frame states and restarts on bytes and state entry.
   always_comb begin
      tmr_run   = (r_q.st == ST_OP) || (r_q.st == ST_LEN) ||
                  (r_q.st == ST_PAYLOAD) || (r_q.st == ST_CHK);
      tmr_clear = bus.rx_update || (r_d.st != r_q.st);
   end

   idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmr_clear),
      .run    (tmr_run),
      .expire (tmr_expire)
   );

   assign bus.cmd_valid   = r_q.valid;
   assign bus.cmd_op      = r_q.op;
   assign bus.cmd_len     = r_q.len;
   assign bus.cmd_payload = r_q.payload;
   assign bus.err_pulse   = r_q.err_pulse;
   assign bus.err_code    = r_q.err_code;
   assign dbg_state       = r_q.st;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed frames against rx_frame_ctrl with a queue-based scoreboard.
module tb_rx_frame_ctrl;
   import rx_frame_pkg::*;

   localparam int TIMEOUT = 16;
   localparam int MAX_LEN = 8;
   localparam int PW      = 8 * MAX_LEN;

   typedef struct packed {
      logic [7:0]    op;
      logic [3:0]    len;
      logic [PW-1:0] payload;
      logic [31:0]   vcyc;
   } frame_t;

   typedef struct packed {
      logic [1:0]  code;
      logic [31:0] ecyc;
   } err_exp_t;

   // ---------------- clock / reset ----------------
   logic   clk   = 1'b0;
   logic   reset = 1'b1;
   state_t dbg_state;
   int     cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rx_frame_if #(.MAX_LEN(MAX_LEN)) bus ();

   rx_frame_ctrl #(
      .TIMEOUT (TIMEOUT),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   frame_t   exp_q[$];
   err_exp_t exp_err_q[$];
   int       n_cmp  = 0;
   int       n_fail = 0;

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push_frame(input logic [7:0] op, input logic [3:0] len,
                                      input logic [PW-1:0] payload, input int vcyc);
      frame_t f;
      f.op      = op;
      f.len     = len;
      f.payload = payload;
      f.vcyc    = 32'(vcyc);
      exp_q.push_back(f);
   endfunction

   function automatic void push_err(input logic [1:0] code, input int ecyc);
      err_exp_t e;
      e.code = code;
      e.ecyc = 32'(ecyc);
      exp_err_q.push_back(e);
   endfunction

   // ---------------- driver tasks ----------------
   // Bytes are given MSB-first in 'bytes'; they go out on consecutive cycles.
   task automatic send(input int n, input logic [127:0] bytes);
      for (int i = 0; i < n; i++) begin
         bus.rx_update = 1'b1;
         bus.rx_data   = bytes[8*(n-1-i) +: 8];
         @(posedge clk);
         #1;
      end
      bus.rx_update = 1'b0;
      bus.rx_data   = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},   PW'(bus.cmd_valid),   '0);
      check({tag, "_op"},      PW'(bus.cmd_op),      '0);
      check({tag, "_len"},     PW'(bus.cmd_len),     '0);
      check({tag, "_payload"}, bus.cmd_payload,      '0);
      check({tag, "_errp"},    PW'(bus.err_pulse),   '0);
      check({tag, "_errc"},    PW'(bus.err_code),    '0);
      check({tag, "_state"},   PW'(dbg_state),       PW'(ST_IDLE));
   endtask

   // ---------------- monitor ----------------
   logic prev_hs    = 1'b0;
   logic prev_valid = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         prev_hs    = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (prev_hs) check("valid_after_handshake", PW'(bus.cmd_valid), '0);
         prev_hs = 1'b0;
         if (bus.cmd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_frame: got op %0h len %0d, expected no frame (cycle %0d)",
                        bus.cmd_op, bus.cmd_len, cyc);
            end else begin
               if (!prev_valid) check("valid_rise_cycle", PW'(cyc), PW'(exp_q[0].vcyc));
               check("cmd_op",      PW'(bus.cmd_op),  PW'(exp_q[0].op));
               check("cmd_len",     PW'(bus.cmd_len), PW'(exp_q[0].len));
               check("cmd_payload", bus.cmd_payload,  exp_q[0].payload);
               if (bus.cmd_ready === 1'b1) begin
                  void'(exp_q.pop_front());
                  prev_hs = 1'b1;
               end
            end
         end
         prev_valid = (bus.cmd_valid === 1'b1);
         if (bus.err_pulse === 1'b1) begin
            if (exp_err_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_error: got code %0d, expected no error (cycle %0d)",
                        bus.err_code, cyc);
            end else begin
               err_exp_t e;
               e = exp_err_q.pop_front();
               check("err_code",  PW'(bus.err_code), PW'(e.code));
               check("err_cycle", PW'(cyc),          PW'(e.ecyc));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int c;
      bus.rx_update = 1'b0;
      bus.rx_data   = 8'h00;
      bus.cmd_ready = 1'b1;
      reset         = 1'b1;
      idle(3);
      check_all_zero("reset");
      reset = 1'b0;
      idle(2);

      // Good frame; checksum wraps past 0xFF.
      c = cyc;
      push_frame(8'h10, 4'd2, PW'(16'hBBAA), c + 6);
      send(6, {8'h55, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'h77});
      idle(3);

      // Bad checksum, then a good frame.
      c = cyc;
      push_err(2'd2, c + 6);
      send(6, {8'h55, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'h78});
      idle(2);
      c = cyc;
      push_frame(8'h01, 4'd1, PW'(8'h05), c + 5);
      send(5, {8'h55, 8'h01, 8'h01, 8'h05, 8'h07});
      idle(3);

      // Length too large, then an immediate zero-length frame.
      c = cyc;
      push_err(2'd1, c + 3);
      push_frame(8'h30, 4'd0, '0, c + 7);
      send(7, {8'h55, 8'h20, 8'h09, 8'h55, 8'h30, 8'h00, 8'h30});
      idle(3);

      // Maximum length payload.
      c = cyc;
      push_frame(8'h40, 4'd8, 64'h0807060504030201, c + 12);
      send(12, {8'h55, 8'h40, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h6C});
      idle(3);

      // Held frame with consumer stalled, overrun while held.
      bus.cmd_ready = 1'b0;
      c = cyc;
      push_frame(8'h11, 4'd1, PW'(8'h22), c + 5);
      send(5, {8'h55, 8'h11, 8'h01, 8'h22, 8'h34});
      idle(2);
      c = cyc;
      push_err(2'd0, c + 1);
      send(1, {8'h55});
      idle(3);

      // Overrun in the handshake cycle, then a frame starting the next cycle.
      c = cyc;
      push_err(2'd0, c + 1);
      push_frame(8'h12, 4'd0, '0, c + 5);
      bus.cmd_ready = 1'b1;
      send(5, {8'h55, 8'h55, 8'h12, 8'h00, 8'h12});
      idle(3);
      check("idle_after_frames", PW'(dbg_state), PW'(ST_IDLE));

      // Timeout: silence after the opcode.
      c = cyc;
      push_err(2'd3, c + 2 + TIMEOUT);
      send(2, {8'h55, 8'h10});
      idle(TIMEOUT + 4);
      check("state_after_timeout", PW'(dbg_state), PW'(ST_IDLE));

      // A byte in the last idle cycle prevents the timeout.
      c = cyc;
      push_frame(8'h10, 4'd0, '0, c + 2 + TIMEOUT + 1);
      send(2, {8'h55, 8'h10});
      idle(TIMEOUT - 1);
      send(2, {8'h00, 8'h10});
      idle(3);

      // Reset mid-payload clears everything, no error.
      send(4, {8'h55, 8'h10, 8'h02, 8'hAA});
      reset = 1'b1;
      idle(2);
      check_all_zero("midreset");
      reset = 1'b0;
      idle(2);
      c = cyc;
      push_frame(8'h10, 4'd2, PW'(16'hBBAA), c + 6);
      send(6, {8'h55, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'h77});
      idle(3);

      // Drain, bounded.
      for (int i = 0; i < 50 && (exp_q.size() != 0 || exp_err_q.size() != 0); i++) begin
         @(posedge clk);
      end
      #1;
      check("frames_outstanding", PW'(exp_q.size()),     '0);
      check("errors_outstanding", PW'(exp_err_q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
